// File: rtl/sdram_multi_arbiter.sv
// Single-outstanding-transaction arbiter from N client channels onto one SDRAM controller port.
// Fixed priority (channel 0 highest) by default; define SDRAM_ARB_ROUND_ROBIN_EN for round-robin.
module sdram_multi_arbiter #(
   parameter int N_CH     = 3,
   parameter int ADDR_W   = 24,
   parameter int DATA_W   = 16,
   parameter int WAIT_CYC = 2,
   localparam int MASK_W  = DATA_W / 8,
   localparam int GW      = $clog2(N_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   output logic                     sdram_cmd_valid,
   input  logic                     sdram_cmd_ready,
   output logic                     sdram_rd,
   output logic                     sdram_wr,
   output logic                     sdram_burst,
   output logic [ADDR_W-1:0]        sdram_addr_x16,
   output logic [DATA_W-1:0]        sdram_wdata,
   output logic [MASK_W-1:0]        sdram_wmask,
   input  logic                     sdram_resp_valid,
   input  logic                     sdram_resp_last,
   input  logic [DATA_W-1:0]        sdram_rdata,
   input  logic                     sdram_rdy,
   output logic                     sdram_ack,
   input  logic [N_CH-1:0]          ch_cmd_valid,
   output logic [N_CH-1:0]          ch_cmd_ready,
   input  logic [N_CH-1:0]          ch_rd,
   input  logic [N_CH-1:0]          ch_wr,
   input  logic [N_CH-1:0]          ch_burst,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr_x16,
   input  logic [N_CH*DATA_W-1:0]   ch_wdata,
   input  logic [N_CH*MASK_W-1:0]   ch_wmask,
   output logic [N_CH-1:0]          ch_resp_valid,
   output logic [N_CH-1:0]          ch_resp_last,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic [N_CH-1:0]          ch_rdy,
   input  logic [N_CH-1:0]          ch_ack,
   output logic [GW-1:0]            grant_o,
   output logic                     busy_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   owner_q, owner_d;
   logic [2:0]      wait_cnt_q, wait_cnt_d;
   logic [GW-1:0]   winner;
   logic [GW-1:0]   sel;
   logic            any_valid;
   logic            busy;
   logic            accept;
   logic            live;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   int              idx;

   // Scan downwards so the first valid channel at or after rr_ptr is the last one assigned.
   always_comb begin
      winner = '0;
      idx    = 0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % N_CH;
         if (ch_cmd_valid[idx]) winner = GW'(idx);
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) rr_ptr_d = (winner == GW'(N_CH - 1)) ? '0 : winner + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_ptr_q <= '0;
      else         rr_ptr_q <= rr_ptr_d;
   end
`else
   always_comb begin
      winner = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (ch_cmd_valid[i]) winner = GW'(i);
      end
   end
`endif

   assign any_valid = |ch_cmd_valid;
   assign busy      = (state_q == BUSY);
   assign accept    = !busy && any_valid && sdram_cmd_ready;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d    = winner;
               wait_cnt_d = 3'(WAIT_CYC);
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (wait_cnt_q != 3'd0) wait_cnt_d = wait_cnt_q - 3'd1;
            if (ch_ack[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Every output is forced low while reset is held, even though inputs may still toggle.
   always_comb begin
      sel             = busy ? owner_q : winner;
      live            = rst_ni && (busy || any_valid);
      sdram_cmd_valid = rst_ni && !busy && any_valid;
      sdram_rd        = live && ch_rd[sel];
      sdram_wr        = live && ch_wr[sel];
      sdram_burst     = live && ch_burst[sel];
      sdram_addr_x16  = live ? ch_addr_x16[int'(sel)*ADDR_W +: ADDR_W] : '0;
      sdram_wdata     = live ? ch_wdata[int'(sel)*DATA_W +: DATA_W] : '0;
      sdram_wmask     = live ? ch_wmask[int'(sel)*MASK_W +: MASK_W] : '0;
      ch_cmd_ready    = '0;
      ch_resp_valid   = '0;
      ch_resp_last    = '0;
      ch_rdy          = '0;
      sdram_ack       = 1'b0;
      if (sdram_cmd_valid) ch_cmd_ready[winner] = sdram_cmd_ready;
      if (rst_ni && busy) begin
         ch_resp_valid[owner_q] = sdram_resp_valid;
         ch_resp_last[owner_q]  = sdram_resp_last;
         ch_rdy[owner_q]        = sdram_rdy && (wait_cnt_q == 3'd0);
         sdram_ack              = ch_ack[owner_q];
      end
      ch_rdata = rst_ni ? sdram_rdata : '0;
      grant_o  = rst_ni ? owner_q : '0;
      busy_o   = rst_ni && busy;
   end

endmodule

// File: tb/tb_sdram_multi_arbiter.sv
// Scoreboard bench for sdram_multi_arbiter (N_CH=3, ADDR_W=24, DATA_W=16, WAIT_CYC=2).
// Stimulus pushes timestamped expected events; a negedge monitor pops and compares them.
module tb_sdram_multi_arbiter;

   localparam int N_CH = 3;
   localparam int AW   = 24;
   localparam int DW   = 16;
   localparam int MW   = 2;
   localparam int K_ACC = 0, K_RDY = 1, K_BEAT = 2, K_ACK = 3;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            sdram_cmd_valid, sdram_cmd_ready;
   logic            sdram_rd, sdram_wr, sdram_burst;
   logic [AW-1:0]   sdram_addr_x16;
   logic [DW-1:0]   sdram_wdata;
   logic [MW-1:0]   sdram_wmask;
   logic            sdram_resp_valid, sdram_resp_last;
   logic [DW-1:0]   sdram_rdata;
   logic            sdram_rdy, sdram_ack;
   logic [N_CH-1:0] ch_cmd_valid, ch_cmd_ready, ch_rd, ch_wr, ch_burst;
   logic [N_CH*AW-1:0] ch_addr_x16;
   logic [N_CH*DW-1:0] ch_wdata;
   logic [N_CH*MW-1:0] ch_wmask;
   logic [N_CH-1:0] ch_resp_valid, ch_resp_last, ch_rdy, ch_ack;
   logic [DW-1:0]   ch_rdata;
   logic [1:0]      grant_o;
   logic            busy_o;

   sdram_multi_arbiter #(.N_CH(N_CH), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(2)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .sdram_cmd_valid(sdram_cmd_valid), .sdram_cmd_ready(sdram_cmd_ready),
      .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_burst(sdram_burst),
      .sdram_addr_x16(sdram_addr_x16), .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask),
      .sdram_resp_valid(sdram_resp_valid), .sdram_resp_last(sdram_resp_last),
      .sdram_rdata(sdram_rdata), .sdram_rdy(sdram_rdy), .sdram_ack(sdram_ack),
      .ch_cmd_valid(ch_cmd_valid), .ch_cmd_ready(ch_cmd_ready),
      .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_burst(ch_burst),
      .ch_addr_x16(ch_addr_x16), .ch_wdata(ch_wdata), .ch_wmask(ch_wmask),
      .ch_resp_valid(ch_resp_valid), .ch_resp_last(ch_resp_last), .ch_rdata(ch_rdata),
      .ch_rdy(ch_rdy), .ch_ack(ch_ack), .grant_o(grant_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          kind;
      int          cyc;
      logic [63:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   function automatic logic [63:0] mk_acc(input logic [7:0] rv, input logic rd, input logic wr,
                                          input logic bu, input logic [23:0] a,
                                          input logic [15:0] wd, input logic [1:0] wm);
      return {wd, 6'b0, wm, rv, 5'b0, rd, wr, bu, a};
   endfunction

   task automatic push(input int kind, input int c, input logic [63:0] v);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [63:0] v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event kind=%0d cyc=%0d actual=%h required=none", kind, cyc, v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.val != v) begin
            errors++;
            $display("FAIL event actual kind=%0d cyc=%0d val=%h required kind=%0d cyc=%0d val=%h",
                     kind, cyc, v, e.kind, e.cyc, e.val);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_ni) begin
         if (sdram_cmd_valid && sdram_cmd_ready && (|ch_cmd_ready))
            observe(K_ACC, {sdram_wdata, 6'b0, sdram_wmask, 8'(ch_cmd_ready), 5'b0,
                            sdram_rd, sdram_wr, sdram_burst, sdram_addr_x16});
         if (|ch_rdy) observe(K_RDY, 64'(ch_rdy));
         if (|ch_resp_valid)
            observe(K_BEAT, (64'(ch_resp_valid) << 32) | (64'(ch_resp_last) << 24) | 64'(ch_rdata));
         if (sdram_ack) observe(K_ACK, 64'(grant_o));
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic set_ch(input int i, input logic rd, input logic wr, input logic bu,
                         input logic [23:0] a, input logic [15:0] wd, input logic [1:0] wm);
      ch_rd[i]               = rd;
      ch_wr[i]               = wr;
      ch_burst[i]            = bu;
      ch_addr_x16[i*AW +: AW] = a;
      ch_wdata[i*DW +: DW]    = wd;
      ch_wmask[i*MW +: MW]    = wm;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   int c;
   int eg[4];

   initial begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      eg = '{0, 1, 2, 0};
`else
      eg = '{0, 0, 0, 0};
`endif
      rst_ni = 1'b0;
      sdram_cmd_ready = 1'b0; sdram_resp_valid = 1'b0; sdram_resp_last = 1'b0;
      sdram_rdata = '0; sdram_rdy = 1'b0;
      ch_cmd_valid = '0; ch_rd = '0; ch_wr = '0; ch_burst = '0;
      ch_addr_x16 = '0; ch_wdata = '0; ch_wmask = '0; ch_ack = '0;
      repeat (3) @(posedge clk);
      at_neg();
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_cmd_valid", 64'(sdram_cmd_valid), 64'd0);
      rst_ni = 1'b1;
      tick();

      // ch0 and ch2 contend: ch0 first, ch2 one cycle after the ack
      tick(); c = cyc;
      set_ch(0, 1'b1, 1'b0, 1'b0, 24'h000100, 16'h1111, 2'b11);
      set_ch(2, 1'b0, 1'b1, 1'b0, 24'h000300, 16'h3333, 2'b10);
      ch_cmd_valid = 3'b101; sdram_cmd_ready = 1'b1;
      push(K_ACC, c, mk_acc(8'b001, 1'b1, 1'b0, 1'b0, 24'h000100, 16'h1111, 2'b11));
      at_neg();
      chk("t2_ready_onehot", 64'(ch_cmd_ready), 64'b001);
      tick(); ch_cmd_valid = 3'b100; ch_ack = 3'b001; push(K_ACK, c + 1, 64'd0);
      tick(); ch_ack = '0;
      push(K_ACC, c + 2, mk_acc(8'b100, 1'b0, 1'b1, 1'b0, 24'h000300, 16'h3333, 2'b10));
      tick(); ch_cmd_valid = '0; ch_ack = 3'b100; push(K_ACK, c + 3, 64'd2);
      tick(); ch_ack = '0;

      // ch1 read: completion hidden for WAIT_CYC cycles after accept
      tick(); c = cyc;
      set_ch(1, 1'b1, 1'b0, 1'b0, 24'h001234, 16'h0000, 2'b00);
      ch_cmd_valid = 3'b010;
      push(K_ACC, c, mk_acc(8'b010, 1'b1, 1'b0, 1'b0, 24'h001234, 16'h0000, 2'b00));
      tick(); ch_cmd_valid = '0; sdram_rdy = 1'b1;
      at_neg();
      chk("t3_rdy_hidden", 64'(ch_rdy), 64'd0);
      chk("t3_busy", 64'(busy_o), 64'd1);
      tick();
      tick(); push(K_RDY, c + 3, 64'b010); ch_ack = 3'b010; push(K_ACK, c + 3, 64'd1);
      tick(); sdram_rdy = 1'b0; ch_ack = '0;

      // ch2 burst of 8 beats
      tick(); c = cyc;
      set_ch(2, 1'b1, 1'b0, 1'b1, 24'h002000, 16'h0000, 2'b00);
      ch_cmd_valid = 3'b100;
      push(K_ACC, c, mk_acc(8'b100, 1'b1, 1'b0, 1'b1, 24'h002000, 16'h0000, 2'b00));
      tick(); ch_cmd_valid = '0;
      for (int k = 0; k < 8; k++) begin
         sdram_resp_valid = 1'b1;
         sdram_resp_last  = (k == 7);
         sdram_rdata      = 16'hA000 + 16'(k);
         push(K_BEAT, c + 1 + k, (64'(3'b100) << 32) | (64'((k == 7) ? 3'b100 : 3'b000) << 24)
                                 | 64'(16'hA000 + 16'(k)));
         at_neg();
         chk("t4_others_quiet", 64'(ch_resp_valid[1:0]), 64'd0);
         tick();
      end
      sdram_resp_valid = 1'b0; sdram_resp_last = 1'b0; sdram_rdy = 1'b1;
      push(K_RDY, c + 9, 64'b100); ch_ack = 3'b100; push(K_ACK, c + 9, 64'd2);
      tick(); sdram_rdy = 1'b0; ch_ack = '0;

      // non-owner ack ignored
      tick(); c = cyc;
      set_ch(1, 1'b0, 1'b1, 1'b0, 24'h005555, 16'hBEEF, 2'b01);
      ch_cmd_valid = 3'b010;
      push(K_ACC, c, mk_acc(8'b010, 1'b0, 1'b1, 1'b0, 24'h005555, 16'hBEEF, 2'b01));
      tick(); ch_cmd_valid = '0; ch_ack = 3'b001;
      at_neg();
      chk("t5_sdram_ack", 64'(sdram_ack), 64'd0);
      tick(); ch_ack = 3'b010; push(K_ACK, c + 2, 64'd1);
      at_neg();
      chk("t5_still_busy", 64'(busy_o), 64'd1);
      tick(); ch_ack = '0;
      at_neg();
      chk("t5_idle", 64'(busy_o), 64'd0);

      // reset in the middle of a transaction
      tick(); c = cyc;
      set_ch(0, 1'b0, 1'b1, 1'b0, 24'h00ABCD, 16'h1234, 2'b11);
      ch_cmd_valid = 3'b001;
      push(K_ACC, c, mk_acc(8'b001, 1'b0, 1'b1, 1'b0, 24'h00ABCD, 16'h1234, 2'b11));
      tick(); ch_cmd_valid = 3'b101;
      #2 rst_ni = 1'b0;
      #1;
      chk("t1_busy", 64'(busy_o), 64'd0);
      chk("t1_cmd_valid", 64'(sdram_cmd_valid), 64'd0);
      chk("t1_cmd_ready", 64'(ch_cmd_ready), 64'd0);
      chk("t1_addr", 64'(sdram_addr_x16), 64'd0);
      ch_ack = 3'b001;
      #1;
      chk("t1_no_ack", 64'(sdram_ack), 64'd0);
      repeat (2) @(posedge clk);
      ch_cmd_valid = '0; ch_ack = '0;
      #2 rst_ni = 1'b1;
      tick();

      // all three channels requesting continuously
      tick(); c = cyc;
      for (int i = 0; i < 3; i++)
         set_ch(i, 1'b1, 1'b0, 1'b0, 24'h600000 + 24'(i), 16'h0000, 2'b00);
      ch_cmd_valid = 3'b111; sdram_cmd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push(K_ACC, cyc, mk_acc(8'(1 << eg[k]), 1'b1, 1'b0, 1'b0, 24'h600000 + 24'(eg[k]),
                                 16'h0000, 2'b00));
         tick(); ch_ack = 3'b111; push(K_ACK, cyc, 64'(eg[k]));
         tick(); ch_ack = '0;
      end
      ch_cmd_valid = '0; sdram_cmd_ready = 1'b0;
      repeat (4) tick();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
